// File: rtl/rv64_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv64_pkg
//  Description : Shared RV64I decode definitions: opcode constants, ALU
//                operation encoding, load/store size codes, immediate format
//                selector, ID/EX pipeline record and small decode helpers.
//  Contents    : OPC_*      7-bit major opcodes
//                alu_op_e   4-bit ALU operation code
//                MEM_*      load/store funct3 size codes
//                imm_fmt_e  immediate format selector for idu_imm_gen
//                idex_t     ID/EX pipeline register contents
//  Revision    : 1.0 - initial release
// ============================================================================
package rv64_pkg;

    localparam int XLEN_W = 64;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ALU operation code carried to EX
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_PASS = 4'd10
    } alu_op_e;

    // Load/store access size (funct3 of LOAD/STORE)
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_D  = 3'b011;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;
    localparam logic [2:0] MEM_WU = 3'b110;

    // Canonical encodings
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    // Immediate format selector
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_SH6  = 3'd6,   // 64-bit shift amount, instr[25:20]
        IMM_SH5  = 3'd7    // 32-bit shift amount, instr[24:20]
    } imm_fmt_e;

    // ID/EX pipeline register contents
    typedef struct packed {
        logic [XLEN_W-1:0] pc;
        logic [XLEN_W-1:0] snxt_pc;
        logic [XLEN_W-1:0] src1;
        logic [XLEN_W-1:0] src2;
        logic [XLEN_W-1:0] rs2_val;
        logic [XLEN_W-1:0] imm;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              wen;
        alu_op_e           alu_op;
        logic              word;
        logic              mem_rd;
        logic              mem_wr;
        logic [2:0]        mem_size;
        logic              branch;
        logic [2:0]        br_type;
        logic              jal;
        logic              jalr;
        logic              ebreak;
        logic              illegal;
        logic              valid;
    } idex_t;

    // Which immediate layout an opcode uses. Shift-immediates (funct3 001/101)
    // carry a zero-extended shift amount instead of a signed I immediate.
    function automatic imm_fmt_e imm_fmt_sel(input logic [6:0] opcode,
                                             input logic [2:0] funct3);
        imm_fmt_e fmt;
        fmt = IMM_NONE;
        case (opcode)
            OPC_LUI, OPC_AUIPC:  fmt = IMM_U;
            OPC_JAL:             fmt = IMM_J;
            OPC_JALR, OPC_LOAD:  fmt = IMM_I;
            OPC_BRANCH:          fmt = IMM_B;
            OPC_STORE:           fmt = IMM_S;
            OPC_OP_IMM:          fmt = (funct3[1:0] == 2'b01) ? IMM_SH6 : IMM_I;
            OPC_OP_IMM32:        fmt = (funct3[1:0] == 2'b01) ? IMM_SH5 : IMM_I;
            default:             fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    // funct3 -> ALU op. 'alt' is instr[30]; it selects SUB only for register
    // forms (in OP-IMM that bit belongs to the immediate) and SRA for both.
    function automatic alu_op_e alu_op_dec(input logic [2:0] funct3,
                                           input logic       alt,
                                           input logic       reg_op);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (reg_op && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idu_imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : idu_imm_gen
//  Description : Combinational immediate generator. Assembles the I/S/B/U/J
//                immediates (sign-extended to 64 bits) and the zero-extended
//                shift amounts from the instruction word.
//  Ports       : instr_i  in  25  instruction bits [31:7]
//                fmt_i    in   3  immediate format select (imm_fmt_e)
//                imm_o    out 64  immediate value
//  Revision    : 1.0 - initial release
// ============================================================================
module idu_imm_gen
    import rv64_pkg::*;
(
    input  logic [31:7]       instr_i,
    input  imm_fmt_e          fmt_i,
    output logic [XLEN_W-1:0] imm_o
);

    logic sign;
    assign sign = instr_i[31];

    always_comb begin
        imm_o = '0;
        case (fmt_i)
            IMM_I:   imm_o = {{52{sign}}, instr_i[31:20]};
            IMM_S:   imm_o = {{52{sign}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{51{sign}}, sign, instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {{32{sign}}, instr_i[31:12], 12'h000};
            IMM_J:   imm_o = {{43{sign}}, sign, instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            IMM_SH6: imm_o = {58'd0, instr_i[25:20]};
            IMM_SH5: imm_o = {59'd0, instr_i[24:20]};
            default: imm_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/idu.sv
`default_nettype none
// ============================================================================
//  Module      : idu
//  Description : RV64I instruction-decode stage. Decodes the fetch register,
//                reads the register file with write-back bypass, builds the
//                ALU operands and control fields, and loads them into the
//                ID/EX register one cycle later. Detects load-use hazards.
//  Ports       : clk, rstn (sync, active low)
//                idu_update, flush_nop      pipeline control
//                ifu_*                      fetch register contents
//                rs1/rs2_addr, rs1/rs2_data register file read port
//                wb_wen, wb_rd, wb_data     write-back bypass
//                hazard_stop                load-use stall request to fetch
//                idu_*                      ID/EX register outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module idu
    import rv64_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            idu_update,
    input  logic            flush_nop,
    input  logic [XLEN-1:0] ifu_pc,
    input  logic [31:0]     ifu_instr,
    input  logic [XLEN-1:0] ifu_snxt_pc,
    input  logic            ifu_valid,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            hazard_stop,
    output logic [XLEN-1:0] idu_pc,
    output logic [XLEN-1:0] idu_snxt_pc,
    output logic [XLEN-1:0] idu_src1,
    output logic [XLEN-1:0] idu_src2,
    output logic [XLEN-1:0] idu_rs2_val,
    output logic [XLEN-1:0] idu_imm,
    output logic [4:0]      idu_rs1,
    output logic [4:0]      idu_rs2,
    output logic [4:0]      idu_rd,
    output logic            idu_wen,
    output logic [3:0]      idu_alu_op,
    output logic            idu_word,
    output logic            idu_mem_rd,
    output logic            idu_mem_wr,
    output logic [2:0]      idu_mem_size,
    output logic            idu_branch,
    output logic [2:0]      idu_br_type,
    output logic            idu_jal,
    output logic            idu_jalr,
    output logic            idu_ebreak,
    output logic            idu_illegal,
    output logic            idu_valid
);

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd_field;
    logic       alt_bit;

    assign opcode   = ifu_instr[6:0];
    assign funct3   = ifu_instr[14:12];
    assign rd_field = ifu_instr[11:7];
    assign alt_bit  = ifu_instr[30];
    assign rs1_addr = ifu_instr[19:15];
    assign rs2_addr = ifu_instr[24:20];

    // ------------------------------------------------------------------
    // Immediate
    // ------------------------------------------------------------------
    imm_fmt_e          imm_fmt;
    logic [XLEN_W-1:0] imm;

    assign imm_fmt = imm_fmt_sel(opcode, funct3);

    idu_imm_gen u_imm_gen (
        .instr_i (ifu_instr[31:7]),
        .fmt_i   (imm_fmt),
        .imm_o   (imm)
    );

    // ------------------------------------------------------------------
    // Register operands with write-back bypass. The regfile is written at
    // the same edge that ID/EX captures, so the value being written this
    // cycle must be taken from wb_data. x0 is hard zero.
    // ------------------------------------------------------------------
    logic [XLEN_W-1:0] rs1_val;
    logic [XLEN_W-1:0] rs2_val;

    always_comb begin
        if (rs1_addr == 5'd0)
            rs1_val = '0;
        else if (wb_wen && (wb_rd == rs1_addr))
            rs1_val = wb_data;
        else
            rs1_val = rs1_data;

        if (rs2_addr == 5'd0)
            rs2_val = '0;
        else if (wb_wen && (wb_rd == rs2_addr))
            rs2_val = wb_data;
        else
            rs2_val = rs2_data;
    end

    // ------------------------------------------------------------------
    // Main decode
    // ------------------------------------------------------------------
    idex_t dec;
    logic  writes_rd;

    always_comb begin
        dec           = '0;
        writes_rd     = 1'b0;
        dec.pc        = ifu_pc;
        dec.snxt_pc   = ifu_snxt_pc;
        dec.rs1       = rs1_addr;
        dec.rs2       = rs2_addr;
        dec.imm       = imm;
        dec.rs2_val   = rs2_val;
        dec.src1      = rs1_val;
        dec.src2      = imm;
        dec.alu_op    = ALU_ADD;
        dec.mem_size  = funct3;
        dec.br_type   = funct3;
        dec.valid     = 1'b1;

        case (opcode)
            OPC_LUI: begin
                dec.src1  = '0;
                writes_rd = 1'b1;
            end
            OPC_AUIPC: begin
                dec.src1  = ifu_pc;
                writes_rd = 1'b1;
            end
            // Jumps compute the link value pc+4 in the ALU; the target is
            // formed in EX from pc/rs1 and idu_imm.
            OPC_JAL: begin
                dec.src1  = ifu_pc;
                dec.src2  = 64'd4;
                dec.jal   = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_JALR: begin
                dec.src1  = ifu_pc;
                dec.src2  = 64'd4;
                dec.jalr  = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                dec.src2   = rs2_val;
                dec.alu_op = ALU_SUB;
                dec.branch = 1'b1;
            end
            OPC_LOAD: begin
                dec.mem_rd = 1'b1;
                writes_rd  = 1'b1;
            end
            OPC_STORE: begin
                dec.mem_wr = 1'b1;
            end
            OPC_OP_IMM: begin
                dec.alu_op = alu_op_dec(funct3, alt_bit, 1'b0);
                writes_rd  = 1'b1;
            end
            OPC_OP: begin
                dec.src2   = rs2_val;
                dec.alu_op = alu_op_dec(funct3, alt_bit, 1'b1);
                writes_rd  = 1'b1;
            end
            OPC_OP_IMM32: begin
                dec.alu_op = alu_op_dec(funct3, alt_bit, 1'b0);
                dec.word   = 1'b1;
                writes_rd  = 1'b1;
            end
            OPC_OP32: begin
                dec.src2   = rs2_val;
                dec.alu_op = alu_op_dec(funct3, alt_bit, 1'b1);
                dec.word   = 1'b1;
                writes_rd  = 1'b1;
            end
            OPC_SYSTEM: begin
                if (ifu_instr == INSTR_EBREAK)
                    dec.ebreak  = 1'b1;
                else
                    dec.illegal = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase

        // Instructions without a destination carry rd=0 so downstream
        // forwarding and hazard logic never match on immediate bits.
        dec.rd  = writes_rd ? rd_field : 5'd0;
        dec.wen = writes_rd && (rd_field != 5'd0);
    end

    // ------------------------------------------------------------------
    // Load-use hazard. Deliberately not gated by flush_nop: the flush wins
    // in the register update below, and fetch prioritises the redirect.
    // ------------------------------------------------------------------
    idex_t idex_q;
    idex_t idex_d;
    logic  uses_rs1;
    logic  uses_rs2;

    assign uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) ||
                        (opcode == OPC_JAL));
    assign uses_rs2 = (opcode == OPC_OP)     || (opcode == OPC_OP32) ||
                      (opcode == OPC_BRANCH) || (opcode == OPC_STORE);

    assign hazard_stop = ifu_valid && idex_q.valid && idex_q.mem_rd &&
                         (idex_q.rd != 5'd0) &&
                         ((uses_rs1 && (rs1_addr == idex_q.rd)) ||
                          (uses_rs2 && (rs2_addr == idex_q.rd)));

    // ------------------------------------------------------------------
    // ID/EX next state: a bubble keeps the datapath fields (pc follows
    // ifu_pc) but clears every control bit that could cause a side effect.
    // ------------------------------------------------------------------
    always_comb begin
        idex_d = dec;
        if (flush_nop || hazard_stop || !ifu_valid) begin
            idex_d.valid   = 1'b0;
            idex_d.wen     = 1'b0;
            idex_d.mem_rd  = 1'b0;
            idex_d.mem_wr  = 1'b0;
            idex_d.branch  = 1'b0;
            idex_d.jal     = 1'b0;
            idex_d.jalr    = 1'b0;
            idex_d.ebreak  = 1'b0;
            idex_d.illegal = 1'b0;
            idex_d.rd      = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idex_q    <= '0;
            idex_q.pc <= RESET_PC;
        end else if (idu_update) begin
            idex_q    <= idex_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign idu_pc       = idex_q.pc;
    assign idu_snxt_pc  = idex_q.snxt_pc;
    assign idu_src1     = idex_q.src1;
    assign idu_src2     = idex_q.src2;
    assign idu_rs2_val  = idex_q.rs2_val;
    assign idu_imm      = idex_q.imm;
    assign idu_rs1      = idex_q.rs1;
    assign idu_rs2      = idex_q.rs2;
    assign idu_rd       = idex_q.rd;
    assign idu_wen      = idex_q.wen;
    assign idu_alu_op   = idex_q.alu_op;
    assign idu_word     = idex_q.word;
    assign idu_mem_rd   = idex_q.mem_rd;
    assign idu_mem_wr   = idex_q.mem_wr;
    assign idu_mem_size = idex_q.mem_size;
    assign idu_branch   = idex_q.branch;
    assign idu_br_type  = idex_q.br_type;
    assign idu_jal      = idex_q.jal;
    assign idu_jalr     = idex_q.jalr;
    assign idu_ebreak   = idex_q.ebreak;
    assign idu_illegal  = idex_q.illegal;
    assign idu_valid    = idex_q.valid;

endmodule
`default_nettype wire

// File: tb/tb_idu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idu
//  Description : Self-checking bench for idu. Directed scenarios plus a
//                randomized run compared against a behavioural decode model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_idu;
    import rv64_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        idu_update, flush_nop, ifu_valid;
    logic [63:0] ifu_pc, ifu_snxt_pc;
    logic [31:0] ifu_instr;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_data, rs2_data;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        hazard_stop;
    logic [63:0] idu_pc, idu_snxt_pc, idu_src1, idu_src2, idu_rs2_val, idu_imm;
    logic [4:0]  idu_rs1, idu_rs2, idu_rd;
    logic        idu_wen, idu_word, idu_mem_rd, idu_mem_wr, idu_branch;
    logic [3:0]  idu_alu_op;
    logic [2:0]  idu_mem_size, idu_br_type;
    logic        idu_jal, idu_jalr, idu_ebreak, idu_illegal, idu_valid;

    int n_vec = 0;
    int n_err = 0;

    idu #(.XLEN(64), .RESET_PC(64'h0)) dut (
        .clk(clk), .rstn(rstn), .idu_update(idu_update), .flush_nop(flush_nop),
        .ifu_pc(ifu_pc), .ifu_instr(ifu_instr), .ifu_snxt_pc(ifu_snxt_pc),
        .ifu_valid(ifu_valid), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_wen(wb_wen), .wb_rd(wb_rd),
        .wb_data(wb_data), .hazard_stop(hazard_stop), .idu_pc(idu_pc),
        .idu_snxt_pc(idu_snxt_pc), .idu_src1(idu_src1), .idu_src2(idu_src2),
        .idu_rs2_val(idu_rs2_val), .idu_imm(idu_imm), .idu_rs1(idu_rs1),
        .idu_rs2(idu_rs2), .idu_rd(idu_rd), .idu_wen(idu_wen),
        .idu_alu_op(idu_alu_op), .idu_word(idu_word), .idu_mem_rd(idu_mem_rd),
        .idu_mem_wr(idu_mem_wr), .idu_mem_size(idu_mem_size),
        .idu_branch(idu_branch), .idu_br_type(idu_br_type), .idu_jal(idu_jal),
        .idu_jalr(idu_jalr), .idu_ebreak(idu_ebreak), .idu_illegal(idu_illegal),
        .idu_valid(idu_valid)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model of the ID/EX register contents
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        valid, wen;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] pc, snxt, src1, src2, imm, rs2v;
        logic [3:0]  alu;
        logic        word, mem_rd, mem_wr, branch, jal, jalr, ebreak, illegal;
        logic [2:0]  f3;
        logic        rd_chk, src_chk, imm_chk, alu_chk;
    } exp_t;

    exp_t m;

    function automatic logic [63:0] opval(input logic [4:0] a, input logic [63:0] d);
        if (a == 5'd0) return 64'd0;
        if (wb_wen && wb_rd == a) return wb_data;
        return d;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic b30, input logic is_reg);
        case (f3)
            3'd0: return (is_reg && b30) ? ALU_SUB : ALU_ADD;
            3'd1: return ALU_SLL;
            3'd2: return ALU_SLT;
            3'd3: return ALU_SLTU;
            3'd4: return ALU_XOR;
            3'd5: return b30 ? ALU_SRA : ALU_SRL;
            3'd6: return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic exp_t ref_decode();
        exp_t e;
        logic [31:0] i;
        logic [6:0]  op;
        logic [63:0] a, b;
        logic        wr;
        i  = ifu_instr;
        op = i[6:0];
        a  = opval(i[19:15], rs1_data);
        b  = opval(i[24:20], rs2_data);
        e = '0;
        wr = 1'b0;
        e.valid = 1'b1; e.pc = ifu_pc; e.snxt = ifu_snxt_pc;
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rs2v = b; e.f3 = i[14:12];
        e.alu = ALU_ADD; e.src_chk = 1'b1; e.imm_chk = 1'b1; e.alu_chk = 1'b1;
        case (op)
            7'h37: begin wr = 1; e.imm = 64'($signed({i[31:12], 12'h0})); e.src1 = 0; e.src2 = e.imm; end
            7'h17: begin wr = 1; e.imm = 64'($signed({i[31:12], 12'h0})); e.src1 = ifu_pc; e.src2 = e.imm; end
            7'h6F: begin wr = 1; e.jal = 1; e.src1 = ifu_pc; e.src2 = 4;
                         e.imm = 64'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            7'h67: begin wr = 1; e.jalr = 1; e.src1 = ifu_pc; e.src2 = 4; e.imm = 64'($signed(i[31:20])); end
            7'h63: begin e.branch = 1; e.src1 = a; e.src2 = b; e.alu_chk = 0;
                         e.imm = 64'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
            7'h03: begin wr = 1; e.mem_rd = 1; e.imm = 64'($signed(i[31:20])); e.src1 = a; e.src2 = e.imm; end
            7'h23: begin e.mem_wr = 1; e.imm = 64'($signed({i[31:25], i[11:7]})); e.src1 = a; e.src2 = e.imm; end
            7'h13: begin wr = 1; e.alu = ref_alu(i[14:12], i[30], 0); e.src1 = a;
                         e.imm = (i[13:12] == 2'b01) ? 64'(i[25:20]) : 64'($signed(i[31:20])); e.src2 = e.imm; end
            7'h1B: begin wr = 1; e.word = 1; e.alu = ref_alu(i[14:12], i[30], 0); e.src1 = a;
                         e.imm = (i[13:12] == 2'b01) ? 64'(i[24:20]) : 64'($signed(i[31:20])); e.src2 = e.imm; end
            7'h33: begin wr = 1; e.alu = ref_alu(i[14:12], i[30], 1); e.src1 = a; e.src2 = b; e.imm_chk = 0; end
            7'h3B: begin wr = 1; e.word = 1; e.alu = ref_alu(i[14:12], i[30], 1); e.src1 = a; e.src2 = b; e.imm_chk = 0; end
            7'h73: begin e.src_chk = 0; e.imm_chk = 0; e.alu_chk = 0;
                         if (i == 32'h0010_0073) e.ebreak = 1; else e.illegal = 1; end
            default: begin e.illegal = 1; e.src_chk = 0; e.imm_chk = 0; e.alu_chk = 0; end
        endcase
        e.rd_chk = wr;
        e.rd  = wr ? i[11:7] : 5'd0;
        e.wen = wr && (i[11:7] != 5'd0);
        return e;
    endfunction

    function automatic logic ref_haz();
        logic [6:0] op;
        logic u1, u2;
        op = ifu_instr[6:0];
        u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
        u2 = (op == 7'h33 || op == 7'h3B || op == 7'h63 || op == 7'h23);
        return ifu_valid && m.valid && m.mem_rd && (m.rd != 0) &&
               ((u1 && ifu_instr[19:15] == m.rd) || (u2 && ifu_instr[24:20] == m.rd));
    endfunction

    // Advance one clock; model computes the ID/EX update from the inputs
    // currently applied, outputs are sampled 1 time unit after the edge.
    task automatic tick();
        exp_t nx;
        nx = m;
        if (idu_update) begin
            nx = ref_decode();
            if (flush_nop || ref_haz() || !ifu_valid) begin
                nx.valid = 0; nx.wen = 0; nx.mem_rd = 0; nx.mem_wr = 0; nx.branch = 0;
                nx.jal = 0; nx.jalr = 0; nx.ebreak = 0; nx.illegal = 0; nx.rd = 0;
            end
        end
        @(posedge clk);
        #1;
        m = nx;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [63:0] pc);
        @(negedge clk);
        idu_update = 1; flush_nop = 0; ifu_valid = 1;
        ifu_instr = ins; ifu_pc = pc; ifu_snxt_pc = pc + 64'd4;
        rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
        wb_wen = 0; wb_rd = 0; wb_data = 0;
        #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rstn = 0; idu_update = 1; flush_nop = 0; ifu_valid = 0;
        ifu_instr = 32'h0000_0013; ifu_pc = 0; ifu_snxt_pc = 4;
        rs1_data = 0; rs2_data = 0; wb_wen = 0; wb_rd = 0; wb_data = 0;
        repeat (2) @(posedge clk);
        #1;
        m = '0;
        n_vec++; if (idu_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", idu_valid); end
        n_vec++; if (idu_pc !== 64'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", idu_pc); end
        n_vec++; if ({idu_wen, idu_mem_rd, idu_mem_wr, idu_illegal} !== 4'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {idu_wen, idu_mem_rd, idu_mem_wr, idu_illegal}); end
        @(negedge clk);
        rstn = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++; if ({idu_valid, idu_wen} !== 2'b00) begin n_err++; $display("FAIL idle_ctrl[%0d]: got %b want 00", k, {idu_valid, idu_wen}); end
            n_vec++; if (idu_pc !== 64'h0) begin n_err++; $display("FAIL idle_pc[%0d]: got %h want 0", k, idu_pc); end
            @(negedge clk);
        end
    endtask

    task automatic test_addi();
        drive(32'h00A0_0093, 64'h100);
        tick();
        n_vec++; if (idu_rd !== 5'd1) begin n_err++; $display("FAIL addi_rd: got %0d want 1", idu_rd); end
        n_vec++; if ({idu_valid, idu_wen} !== 2'b11) begin n_err++; $display("FAIL addi_vw: got %b want 11", {idu_valid, idu_wen}); end
        n_vec++; if (idu_src1 !== 64'd0 || idu_src2 !== 64'd10) begin n_err++; $display("FAIL addi_src: got %h/%h want 0/a", idu_src1, idu_src2); end
        n_vec++; if (idu_alu_op !== ALU_ADD) begin n_err++; $display("FAIL addi_alu: got %0d want %0d", idu_alu_op, ALU_ADD); end
    endtask

    task automatic test_load_use();
        drive(32'h0001_3283, 64'h200);          // ld x5,0(x2)
        n_vec++; if (hazard_stop !== 1'b0) begin n_err++; $display("FAIL lu_pre_haz: got %b want 0", hazard_stop); end
        tick();
        drive(32'h0072_8333, 64'h204);          // add x6,x5,x7
        n_vec++; if (hazard_stop !== 1'b1) begin n_err++; $display("FAIL lu_haz: got %b want 1", hazard_stop); end
        tick();
        n_vec++; if (idu_valid !== 1'b0 || idu_mem_rd !== 1'b0) begin n_err++; $display("FAIL lu_bubble: got v=%b mr=%b want 0 0", idu_valid, idu_mem_rd); end
        drive(32'h0072_8333, 64'h204);          // fetch re-presents the add
        n_vec++; if (hazard_stop !== 1'b0) begin n_err++; $display("FAIL lu_release: got %b want 0", hazard_stop); end
        tick();
        n_vec++; if (idu_valid !== 1'b1 || idu_rs1 !== 5'd5 || idu_rd !== 5'd6) begin n_err++; $display("FAIL lu_add: got v=%b rs1=%0d rd=%0d want 1 5 6", idu_valid, idu_rs1, idu_rd); end
    endtask

    task automatic test_bypass();
        drive(32'h0011_8213, 64'h300);          // addi x4,x3,1
        wb_wen = 1; wb_rd = 3; wb_data = 64'hDEAD; rs1_data = 0;
        tick();
        n_vec++; if (idu_src1 !== 64'hDEAD) begin n_err++; $display("FAIL byp_src1: got %h want dead", idu_src1); end
        drive(32'h0010_0213, 64'h304);          // addi x4,x0,1 with write to x0
        wb_wen = 1; wb_rd = 0; wb_data = 64'hBEEF; rs1_data = 64'h55;
        tick();
        n_vec++; if (idu_src1 !== 64'h0) begin n_err++; $display("FAIL byp_x0: got %h want 0", idu_src1); end
    endtask

    task automatic test_flush();
        drive(32'h0001_3283, 64'h400);          // ld x5,0(x2)
        tick();
        drive(32'h0072_8333, 64'h404);
        flush_nop = 1; #1;
        n_vec++; if (hazard_stop !== 1'b1) begin n_err++; $display("FAIL fl_haz: got %b want 1", hazard_stop); end
        tick();
        n_vec++; if (idu_valid !== 1'b0 || idu_pc !== 64'h404) begin n_err++; $display("FAIL fl_bubble: got v=%b pc=%h want 0 404", idu_valid, idu_pc); end
        drive(32'h0072_8333, 64'h800);          // redirect target
        n_vec++; if (hazard_stop !== 1'b0) begin n_err++; $display("FAIL fl_nohaz: got %b want 0", hazard_stop); end
        tick();
        n_vec++; if (idu_valid !== 1'b1 || idu_pc !== 64'h800) begin n_err++; $display("FAIL fl_next: got v=%b pc=%h want 1 800", idu_valid, idu_pc); end
    endtask

    task automatic test_hold_and_system();
        logic [63:0] pc0, s1, s2, im;
        drive(32'hFFF1_0193, 64'h500);          // addi x3,x2,-1
        tick();
        pc0 = idu_pc; s1 = idu_src1; s2 = idu_src2; im = idu_imm;
        n_vec++; if (im !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL neg_imm: got %h want all ones", im); end
        for (int k = 0; k < 3; k++) begin
            drive($urandom, {$urandom, $urandom});
            idu_update = 0; flush_nop = k[0]; #1;
            tick();
            n_vec++; if (idu_pc !== pc0 || idu_src1 !== s1 || idu_src2 !== s2 || idu_imm !== im || idu_valid !== 1'b1 || idu_rd !== 5'd3) begin
                n_err++; $display("FAIL hold[%0d]: got pc=%h s1=%h s2=%h v=%b rd=%0d want pc=%h s1=%h s2=%h v=1 rd=3", k, idu_pc, idu_src1, idu_src2, idu_valid, idu_rd, pc0, s1, s2);
            end
        end
        drive(32'h0010_0073, 64'h600);
        tick();
        n_vec++; if ({idu_ebreak, idu_illegal, idu_wen, idu_valid} !== 4'b1001) begin n_err++; $display("FAIL ebreak: got %b want 1001", {idu_ebreak, idu_illegal, idu_wen, idu_valid}); end
        drive(32'h0000_008F, 64'h604);          // opcode 0001111, rd=1
        tick();
        n_vec++; if ({idu_ebreak, idu_illegal, idu_wen, idu_valid} !== 4'b0101) begin n_err++; $display("FAIL illegal: got %b want 0101", {idu_ebreak, idu_illegal, idu_wen, idu_valid}); end
    endtask

    task automatic test_random();
        logic [6:0] ops [14] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h73, 7'h0F, 7'h7F};
        logic [31:0] ins;
        logic        h;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 13)];
            ins[11:7]  = 5'($urandom_range(0, 3));
            ins[19:15] = 5'($urandom_range(0, 3));
            ins[24:20] = 5'($urandom_range(0, 3));
            if (ins[6:0] == 7'h73 && $urandom_range(0, 1) == 1) ins = 32'h0010_0073;
            ifu_instr = ins;
            ifu_pc = {$urandom, $urandom}; ifu_snxt_pc = ifu_pc + 64'd4;
            ifu_valid  = ($urandom_range(0, 9) != 0);
            idu_update = ($urandom_range(0, 4) != 0);
            flush_nop  = ($urandom_range(0, 9) == 0);
            rs1_data = {$urandom, $urandom}; rs2_data = {$urandom, $urandom};
            wb_wen = $urandom_range(0, 1); wb_rd = 5'($urandom_range(0, 3)); wb_data = {$urandom, $urandom};
            #1;
            h = ref_haz();
            n_vec++; if (hazard_stop !== h) begin n_err++; $display("FAIL rnd_haz[%0d]: got %b want %b", k, hazard_stop, h); end
            tick();
            n_vec++; if (idu_valid !== m.valid || idu_pc !== m.pc) begin n_err++; $display("FAIL rnd_vpc[%0d]: got %b %h want %b %h", k, idu_valid, idu_pc, m.valid, m.pc); end
            n_vec++; if ({idu_wen, idu_mem_rd, idu_mem_wr, idu_branch, idu_jal, idu_jalr, idu_ebreak, idu_illegal} !== {m.wen, m.mem_rd, m.mem_wr, m.branch, m.jal, m.jalr, m.ebreak, m.illegal}) begin
                n_err++; $display("FAIL rnd_ctrl[%0d]: got %b want %b", k, {idu_wen, idu_mem_rd, idu_mem_wr, idu_branch, idu_jal, idu_jalr, idu_ebreak, idu_illegal}, {m.wen, m.mem_rd, m.mem_wr, m.branch, m.jal, m.jalr, m.ebreak, m.illegal});
            end
            if (!m.valid) begin
                n_vec++; if (idu_rd !== 5'd0) begin n_err++; $display("FAIL rnd_bubble_rd[%0d]: got %0d want 0", k, idu_rd); end
            end else begin
                n_vec++; if (idu_snxt_pc !== m.snxt || idu_rs1 !== m.rs1 || idu_rs2 !== m.rs2 || idu_rs2_val !== m.rs2v || idu_word !== m.word) begin
                    n_err++; $display("FAIL rnd_fields[%0d]: got %h %0d %0d %h %b want %h %0d %0d %h %b", k, idu_snxt_pc, idu_rs1, idu_rs2, idu_rs2_val, idu_word, m.snxt, m.rs1, m.rs2, m.rs2v, m.word);
                end
                if (m.rd_chk) begin
                    n_vec++; if (idu_rd !== m.rd) begin n_err++; $display("FAIL rnd_rd[%0d]: got %0d want %0d", k, idu_rd, m.rd); end
                end
                if (m.src_chk) begin
                    n_vec++; if (idu_src1 !== m.src1 || idu_src2 !== m.src2) begin n_err++; $display("FAIL rnd_src[%0d] instr=%h: got %h %h want %h %h", k, ins, idu_src1, idu_src2, m.src1, m.src2); end
                end
                if (m.imm_chk) begin
                    n_vec++; if (idu_imm !== m.imm) begin n_err++; $display("FAIL rnd_imm[%0d] instr=%h: got %h want %h", k, ins, idu_imm, m.imm); end
                end
                if (m.alu_chk) begin
                    n_vec++; if (idu_alu_op !== m.alu) begin n_err++; $display("FAIL rnd_alu[%0d] instr=%h: got %0d want %0d", k, ins, idu_alu_op, m.alu); end
                end
                if (m.mem_rd || m.mem_wr) begin
                    n_vec++; if (idu_mem_size !== m.f3) begin n_err++; $display("FAIL rnd_msize[%0d]: got %0d want %0d", k, idu_mem_size, m.f3); end
                end
                if (m.branch) begin
                    n_vec++; if (idu_br_type !== m.f3) begin n_err++; $display("FAIL rnd_brtype[%0d]: got %0d want %0d", k, idu_br_type, m.f3); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_bypass();
        test_flush();
        test_hold_and_system();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
